// File: rtl/dvp_capture_pack.sv
// DVP camera capture: frames pixels from vsync/href, packs BYTES_PER_PIXEL bytes per word,
// tags sof/eol/eof and buffers words in a show-ahead FIFO with a valid/ready output.
module dvp_capture_pack #(
    parameter int WIDTH             = 1280,
    parameter int HEIGHT            = 720,
    parameter int BYTES_PER_PIXEL   = 2,
    parameter int LSB_FIRST         = 1,
    parameter int VSYNC_ACTIVE_HIGH = 1,
    parameter int FIFO_DEPTH        = 16
) (
    input  logic                         pclk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         vsync,
    input  logic                         href,
    input  logic [7:0]                   data,
    output logic [8*BYTES_PER_PIXEL-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sof,
    output logic                         out_eol,
    output logic                         out_eof,
    output logic                         line_err,
    output logic                         frame_abort,
    output logic                         overflow,
    input  logic                         clear
);
    localparam int PW = 8 * BYTES_PER_PIXEL;
    localparam int HW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int VW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BW = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [HW-1:0] H_LAST  = HW'(WIDTH - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(HEIGHT - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(BYTES_PER_PIXEL - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_LINE, LINE, LINE_END} state_t;

    typedef struct packed {
        logic [PW-1:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
    } word_t;

    state_t        state;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [BW-1:0] bcnt;
    logic          line_full;
    logic          line_long;
    logic [PW-1:0] pix_buf;
    logic [PW-1:0] pix_next;
    logic          vs_act;
    logic          vs_act_q;
    logic          frame_start;
    logic          start_frame;
    logic          take_byte;
    logic          push_req;
    word_t         push_word;

    // Frame start is the active-to-inactive edge of the vsync pulse.
    assign vs_act      = (VSYNC_ACTIVE_HIGH != 0) ? vsync : ~vsync;
    assign frame_start = vs_act_q & ~vs_act;
    assign start_frame = frame_start && (state != IDLE || enable);
    // line_full stands in for hcnt==WIDTH, which hcnt itself cannot hold.
    assign take_byte   = href && !frame_start && !line_full &&
                         (state == WAIT_LINE || state == LINE);

    always_comb begin
        // NOTE: default first so no path leaves pix_next unassigned (no latch).
        pix_next = pix_buf;
        for (int k = 0; k < BYTES_PER_PIXEL; k++) begin
            if (bcnt == BW'((LSB_FIRST != 0) ? k : BYTES_PER_PIXEL - 1 - k))
                pix_next[8*k +: 8] = data;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_act_q    <= 1'b0;
            state       <= IDLE;
            hcnt        <= '0;
            vcnt        <= '0;
            bcnt        <= '0;
            line_full   <= 1'b0;
            line_long   <= 1'b0;
            pix_buf     <= '0;
            push_req    <= 1'b0;
            push_word   <= '0;
            line_err    <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every test below sees pre-edge values.
            vs_act_q    <= vs_act;
            line_err    <= 1'b0;
            frame_abort <= 1'b0;
            push_req    <= 1'b0;

            if (take_byte) begin
                pix_buf <= pix_next;
                if (bcnt == B_LAST) begin
                    push_req       <= 1'b1;
                    push_word.data <= pix_next;
                    push_word.sof  <= (hcnt == '0) && (vcnt == '0);
                    push_word.eol  <= (hcnt == H_LAST);
                    push_word.eof  <= (hcnt == H_LAST) && (vcnt == V_LAST);
                    bcnt           <= '0;
                    if (hcnt == H_LAST) begin
                        hcnt      <= '0;
                        line_full <= 1'b1;
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end else begin
                    bcnt <= bcnt + BW'(1);
                end
            end

            if (start_frame) begin
                frame_abort <= (state != IDLE);
                hcnt        <= '0;
                vcnt        <= '0;
                bcnt        <= '0;
                line_full   <= 1'b0;
                line_long   <= 1'b0;
                state       <= WAIT_LINE;
            end else begin
                case (state)
                    IDLE: ;
                    WAIT_LINE: if (href) state <= LINE;
                    LINE: begin
                        if (!href)          state     <= LINE_END;
                        else if (line_full) line_long <= 1'b1;
                    end
                    LINE_END: begin
                        line_err  <= !line_full || (bcnt != '0) || line_long;
                        hcnt      <= '0;
                        bcnt      <= '0;
                        line_full <= 1'b0;
                        line_long <= 1'b0;
                        vcnt      <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
                        state     <= (vcnt == V_LAST) ? IDLE : WAIT_LINE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    word_t         mem [FIFO_DEPTH];
    word_t         head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          pop;
    logic          wr_en;
    logic          drop;

    assign pop   = out_valid && out_ready;
    assign wr_en = push_req && ((count != DEPTH_C) || pop);
    assign drop  = push_req && (count == DEPTH_C) && !pop;

    // NOTE: storage is not reset; out_valid gates everything read from it.
    always_ff @(posedge pclk) begin
        if (wr_en) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            overflow <= drop || (overflow && !clear);
        end
    end

    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? head.data : '0;
    assign out_sof   = out_valid && head.sof;
    assign out_eol   = out_valid && head.eol;
    assign out_eof   = out_valid && head.eof;
endmodule

// File: tb/tb_dvp_capture_pack.sv
// Scoreboard bench for dvp_capture_pack: two 4x2 instances (2-byte LSB-first with a
// 4-entry FIFO, 3-byte MSB-first) share the camera bus and are enabled one at a time.
module tb_dvp_capture_pack;
    logic        pclk;
    logic        rst_n;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        en_a, en_b, rdy_a, rdy_b, clr_a, clr_b;

    logic [15:0] od_a;
    logic        ov_a, sof_a, eol_a, eof_a, le_a_o, fa_a_o, of_a;
    logic [23:0] od_b;
    logic        ov_b, sof_b, eol_b, eof_b, le_b_o, fa_b_o, of_b;

    dvp_capture_pack #(
        .WIDTH(4), .HEIGHT(2), .BYTES_PER_PIXEL(2), .LSB_FIRST(1),
        .VSYNC_ACTIVE_HIGH(1), .FIFO_DEPTH(4)
    ) dut_a (
        .pclk(pclk), .rst_n(rst_n), .enable(en_a), .vsync(vsync), .href(href), .data(data),
        .out_data(od_a), .out_valid(ov_a), .out_ready(rdy_a), .out_sof(sof_a),
        .out_eol(eol_a), .out_eof(eof_a), .line_err(le_a_o), .frame_abort(fa_a_o),
        .overflow(of_a), .clear(clr_a)
    );

    dvp_capture_pack #(
        .WIDTH(4), .HEIGHT(2), .BYTES_PER_PIXEL(3), .LSB_FIRST(0),
        .VSYNC_ACTIVE_HIGH(1), .FIFO_DEPTH(16)
    ) dut_b (
        .pclk(pclk), .rst_n(rst_n), .enable(en_b), .vsync(vsync), .href(href), .data(data),
        .out_data(od_b), .out_valid(ov_b), .out_ready(rdy_b), .out_sof(sof_b),
        .out_eol(eol_b), .out_eof(eof_b), .line_err(le_b_o), .frame_abort(fa_b_o),
        .overflow(of_b), .clear(clr_b)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          le_a = 0, ab_a = 0, le_b = 0, ab_b = 0;
    int          words_a = 0, words_b = 0;
    int          b1_cyc = 0;
    int          rise_cyc = -1;
    int          lat_ref = 0;
    bit          arm_rise = 1'b1;
    logic        prev_ov_a = 1'b0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] act_a, act_b;

    always @(posedge pclk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Monitor: pops and compares whenever a word is handed over, counts pulses.
    always @(negedge pclk) begin
        if (le_a_o) le_a++;
        if (fa_a_o) ab_a++;
        if (le_b_o) le_b++;
        if (fa_b_o) ab_b++;
        if (arm_rise && ov_a && !prev_ov_a) begin
            rise_cyc = cyc;
            arm_rise = 1'b0;
        end
        prev_ov_a = ov_a;
        if (ov_a && rdy_a) begin
            words_a++;
            act_a = {13'd0, od_a, sof_a, eol_a, eof_a};
            if (qa.size() == 0) begin
                checks++;
                $display("FAIL a_unexpected_word: got 0x%0h, want no word", act_a);
            end else begin
                check("a_word", act_a, qa.pop_front());
            end
        end
        if (ov_b && rdy_b) begin
            words_b++;
            act_b = {5'd0, od_b, sof_b, eol_b, eof_b};
            if (qb.size() == 0) begin
                checks++;
                $display("FAIL b_unexpected_word: got 0x%0h, want no word", act_b);
            end else begin
                check("b_word", act_b, qb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic frame_start();
        tick(); vsync = 1'b1;
        tick(); tick(); vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            href = 1'b1;
            data = first + 8'(i);
            if (i == 1) b1_cyc = cyc;
        end
    endtask

    task automatic end_line();
        tick(); href = 1'b0; data = 8'h00;
        repeat (3) tick();
    endtask

    task automatic send_line(input logic [7:0] first, input int n);
        send_bytes(first, n);
        end_line();
    endtask

    task automatic expect_a(input logic [15:0] d, input logic s, input logic e, input logic f);
        qa.push_back({13'd0, d, s, e, f});
    endtask

    task automatic expect_b(input logic [23:0] d, input logic s, input logic e, input logic f);
        qb.push_back({5'd0, d, s, e, f});
    endtask

    task automatic clear_counts();
        le_a = 0; ab_a = 0; le_b = 0; ab_b = 0; words_a = 0; words_b = 0;
    endtask

    task automatic settle(input string name);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check({name, "_drain"}, qa.size() + qb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00;
        en_a = 1'b0; en_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
        repeat (3) @(posedge pclk);
        #1 rst_n = 1'b1;

        @(negedge pclk);
        check("rst_valid_a", ov_a, 0);
        check("rst_data_a", od_a, 0);
        check("rst_tags_a", {sof_a, eol_a, eof_a}, 0);
        check("rst_pulses_a", {le_a_o, fa_a_o}, 0);
        check("rst_overflow_a", of_a, 0);
        check("rst_valid_b", ov_b, 0);
        check("rst_data_b", od_b, 0);

        // enable low: frame start must not leave IDLE
        frame_start();
        send_line(8'hE1, 8);
        send_line(8'hF1, 8);
        repeat (10) tick();
        check("en_low_words_a", words_a, 0);
        check("en_low_words_b", words_b, 0);

        // 2-byte LSB-first frame, with pixel-to-valid latency
        clear_counts();
        en_a = 1'b1; frame_start(); en_a = 1'b0;
        expect_a(16'h0201, 1, 0, 0); expect_a(16'h0403, 0, 0, 0);
        expect_a(16'h0605, 0, 0, 0); expect_a(16'h0807, 0, 1, 0);
        expect_a(16'h1211, 0, 0, 0); expect_a(16'h1413, 0, 0, 0);
        expect_a(16'h1615, 0, 0, 0); expect_a(16'h1817, 0, 1, 1);
        send_line(8'h01, 8);
        lat_ref = b1_cyc;
        send_line(8'h11, 8);
        settle("t1");
        check("t1_valid_latency", rise_cyc - lat_ref, 2);
        check("t1_words", words_a, 8);
        check("t1_line_err", le_a, 0);
        check("t1_abort", ab_a, 0);

        // 3-byte MSB-first frame on the second instance
        clear_counts();
        en_b = 1'b1; frame_start(); en_b = 1'b0;
        expect_b(24'h010203, 1, 0, 0); expect_b(24'h040506, 0, 0, 0);
        expect_b(24'h070809, 0, 0, 0); expect_b(24'h0A0B0C, 0, 1, 0);
        expect_b(24'h111213, 0, 0, 0); expect_b(24'h141516, 0, 0, 0);
        expect_b(24'h171819, 0, 0, 0); expect_b(24'h1A1B1C, 0, 1, 1);
        send_line(8'h01, 12);
        send_line(8'h11, 12);
        settle("t2");
        check("t2_words_b", words_b, 8);
        check("t2_line_err_b", le_b, 0);
        check("t2_words_a", words_a, 0);

        // short first line: 7 bytes -> 3 words, partial byte dropped
        clear_counts();
        en_a = 1'b1; frame_start(); en_a = 1'b0;
        expect_a(16'h2221, 1, 0, 0); expect_a(16'h2423, 0, 0, 0); expect_a(16'h2625, 0, 0, 0);
        expect_a(16'h3231, 0, 0, 0); expect_a(16'h3433, 0, 0, 0);
        expect_a(16'h3635, 0, 0, 0); expect_a(16'h3837, 0, 1, 1);
        send_line(8'h21, 7);
        send_line(8'h31, 8);
        settle("t3");
        check("t3_line_err", le_a, 1);
        check("t3_words", words_a, 7);

        // long first line: 10 bytes -> 4 words, last 2 bytes dropped
        clear_counts();
        en_a = 1'b1; frame_start(); en_a = 1'b0;
        expect_a(16'h4241, 1, 0, 0); expect_a(16'h4443, 0, 0, 0);
        expect_a(16'h4645, 0, 0, 0); expect_a(16'h4847, 0, 1, 0);
        expect_a(16'h5251, 0, 0, 0); expect_a(16'h5453, 0, 0, 0);
        expect_a(16'h5655, 0, 0, 0); expect_a(16'h5857, 0, 1, 1);
        send_line(8'h41, 10);
        send_line(8'h51, 8);
        settle("t4");
        check("t4_line_err", le_a, 1);
        check("t4_words", words_a, 8);

        // mid-frame vsync after 3 pixels of line 1, then a full new frame
        clear_counts();
        en_a = 1'b1; frame_start(); en_a = 1'b0;
        expect_a(16'h6261, 1, 0, 0); expect_a(16'h6463, 0, 0, 0);
        expect_a(16'h6665, 0, 0, 0); expect_a(16'h6867, 0, 1, 0);
        expect_a(16'h7271, 0, 0, 0); expect_a(16'h7473, 0, 0, 0); expect_a(16'h7675, 0, 0, 0);
        expect_a(16'h8281, 1, 0, 0); expect_a(16'h8483, 0, 0, 0);
        expect_a(16'h8685, 0, 0, 0); expect_a(16'h8887, 0, 1, 0);
        expect_a(16'h9291, 0, 0, 0); expect_a(16'h9493, 0, 0, 0);
        expect_a(16'h9695, 0, 0, 0); expect_a(16'h9897, 0, 1, 1);
        send_line(8'h61, 8);
        send_bytes(8'h71, 6);
        tick(); data = 8'h77; vsync = 1'b1;
        tick(); href = 1'b0; vsync = 1'b0; data = 8'h00;
        repeat (3) tick();
        send_line(8'h81, 8);
        send_line(8'h91, 8);
        settle("t5");
        check("t5_abort", ab_a, 1);
        check("t5_line_err", le_a, 0);
        check("t5_words", words_a, 15);

        // consumer stalled for a whole frame: 4 words kept, rest dropped
        clear_counts();
        rdy_a = 1'b0;
        en_a = 1'b1; frame_start(); en_a = 1'b0;
        expect_a(16'hA2A1, 1, 0, 0); expect_a(16'hA4A3, 0, 0, 0);
        expect_a(16'hA6A5, 0, 0, 0); expect_a(16'hA8A7, 0, 1, 0);
        send_line(8'hA1, 8);
        send_line(8'hB1, 8);
        repeat (4) tick();
        @(negedge pclk);
        check("t6_overflow_set", of_a, 1);
        check("t6_valid_held", ov_a, 1);
        check("t6_line_err", le_a, 0);
        tick(); clr_a = 1'b1;
        tick(); clr_a = 1'b0;
        @(negedge pclk);
        check("t6_overflow_cleared", of_a, 0);
        tick(); rdy_a = 1'b1;
        settle("t6");
        check("t6_drained_words", words_a, 4);

        // reset in the middle of a line empties the FIFO at once
        clear_counts();
        rdy_a = 1'b0;
        en_a = 1'b1; frame_start(); en_a = 1'b0;
        send_bytes(8'hC1, 5);
        tick(); href = 1'b0; data = 8'h00;
        repeat (3) tick();
        @(negedge pclk);
        check("t7_valid_before_reset", ov_a, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t7_reset_valid", ov_a, 0);
        check("t7_reset_data", od_a, 0);
        check("t7_reset_tags", {sof_a, eol_a, eof_a}, 0);
        tick(); tick(); rst_n = 1'b1;
        rdy_a = 1'b1;
        repeat (10) tick();
        check("t7_words_after_reset", words_a, 0);

        check("final_queue_a", qa.size(), 0);
        check("final_queue_b", qb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
